// File: rtl/bp_nonsynth_if_watchdog_ctrl.sv
// Interface-stall watchdog sequencer for simulation benches.
// Waits out a warmup window after arming, then counts consecutive valid-without-
// ready cycles per channel. The first channel to reach the timeout is latched.
// The block then drains for a fixed number of cycles so neighbouring monitors can
// flush, and finally reports the timeout and ends the run.
module bp_nonsynth_if_watchdog_ctrl #(
    parameter int    els_p       = 4,
    parameter int    timeout_p   = 10000,
    parameter int    warmup_p    = 100,
    parameter int    drain_p     = 16,
    parameter string dev_p       = "if",
    // Set to 0 to keep the simulation running after the report; useful when a
    // bench wants to observe DONE itself.
    parameter bit    finish_en_p = 1'b1,
    localparam int   IDX_W       = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [els_p-1:0] mask_i,
    input  logic [els_p-1:0] v_i,
    input  logic [els_p-1:0] ready_and_i,
    output logic             armed_o,
    output logic             trip_o,
    output logic [IDX_W-1:0] trip_idx_o,
    output logic [63:0]      trip_cycle_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(timeout_p + 1);
    localparam int WRM_W = (warmup_p > 0) ? $clog2(warmup_p + 1) : 1;
    localparam int DRN_W = $clog2(drain_p + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(timeout_p);
    localparam logic [WRM_W-1:0] WRM_END = WRM_W'(warmup_p);
    localparam logic [DRN_W-1:0] DRN_END = DRN_W'(drain_p);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        ARMED  = 3'd2,
        TRIP   = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [63:0]      cycle_q, cycle_d;
    logic [WRM_W-1:0] warm_q, warm_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0] stall_q [els_p];
    logic [CNT_W-1:0] stall_d [els_p];
    logic             trip_q, trip_d;
    logic [IDX_W-1:0] trip_idx_q, trip_idx_d;
    logic [63:0]      trip_cycle_q, trip_cycle_d;
    logic             done_seen_q;

    logic [els_p-1:0] trip_vec;
    logic             trip_any;
    logic [IDX_W-1:0] trip_sel;

    // Timeout detection from registered counts; lowest index wins a tie.
    always_comb begin
        trip_vec = '0;
        trip_sel = '0;
        for (int i = 0; i < els_p; i++) begin
            trip_vec[i] = (state_q == ARMED) && mask_i[i] && (stall_q[i] == CNT_MAX);
        end
        for (int i = els_p - 1; i >= 0; i--) begin
            if (trip_vec[i]) begin
                trip_sel = IDX_W'(i);
            end
        end
        trip_any = |trip_vec;
    end

    // Sequencer next state, warmup/drain counting and trip capture.
    always_comb begin
        state_d      = state_q;
        warm_d       = warm_q;
        drain_d      = drain_q;
        trip_d       = trip_q;
        trip_idx_d   = trip_idx_q;
        trip_cycle_d = trip_cycle_q;
        cycle_d      = cycle_q + 64'd1;
        case (state_q)
            IDLE: begin
                warm_d  = '0;
                drain_d = '0;
                if (en_i) begin
                    state_d = (warmup_p == 0) ? ARMED : WARMUP;
                end
            end
            WARMUP: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else begin
                    warm_d = warm_q + WRM_W'(1);
                    if (warm_q + WRM_W'(1) == WRM_END) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                // A trip outranks a simultaneous disarm.
                if (trip_any) begin
                    state_d      = TRIP;
                    drain_d      = '0;
                    trip_d       = 1'b1;
                    trip_idx_d   = trip_sel;
                    trip_cycle_d = cycle_q;
                end else if (!en_i) begin
                    state_d = IDLE;
                end
            end
            TRIP: begin
                drain_d = drain_q + DRN_W'(1);
                if (drain_q + DRN_W'(1) == DRN_END) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-channel stall counters: only live while ARMED, frozen once tripped.
    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            stall_d[i] = stall_q[i];
            case (state_q)
                ARMED: begin
                    if (!trip_any) begin
                        if (!en_i || !mask_i[i]) begin
                            stall_d[i] = '0;
                        end else if (v_i[i] && ready_and_i[i]) begin
                            stall_d[i] = '0;
                        end else if (v_i[i] && (stall_q[i] != CNT_MAX)) begin
                            stall_d[i] = stall_q[i] + CNT_W'(1);
                        end
                    end
                end
                TRIP, DONE: begin
                    stall_d[i] = stall_q[i];
                end
                default: begin
                    stall_d[i] = '0;
                end
            endcase
        end
    end

    // State and counter registers; reset returns everything to zero/IDLE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cycle_q      <= '0;
            warm_q       <= '0;
            drain_q      <= '0;
            trip_q       <= 1'b0;
            trip_idx_q   <= '0;
            trip_cycle_q <= '0;
            done_seen_q  <= 1'b0;
            for (int i = 0; i < els_p; i++) begin
                stall_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            warm_q       <= warm_d;
            drain_q      <= drain_d;
            trip_q       <= trip_d;
            trip_idx_q   <= trip_idx_d;
            trip_cycle_q <= trip_cycle_d;
            done_seen_q  <= (state_q == DONE);
            for (int i = 0; i < els_p; i++) begin
                stall_q[i] <= stall_d[i];
            end
        end
    end

    assign armed_o      = (state_q == ARMED);
    assign done_o       = (state_q == DONE);
    assign trip_o       = trip_q;
    assign trip_idx_o   = trip_idx_q;
    assign trip_cycle_o = trip_cycle_q;

`ifndef SYNTHESIS
    // Report once in the first DONE cycle, then end the simulation.
    always @(negedge clk_i) begin
        if (!reset_i && (state_q == DONE) && !done_seen_q) begin
            $display("%s: timeout[%0d] at cycle %0d", dev_p, trip_idx_q, trip_cycle_q);
            if (finish_en_p) begin
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_nonsynth_if_watchdog_ctrl.sv
// Directed bench for the interface watchdog sequencer (els=4, timeout=8,
// warmup=4, drain=4). The end-of-run finish is disabled so DONE can be observed.
module tb_bp_nonsynth_if_watchdog_ctrl;

    localparam int ELS = 4;
    localparam int TMO = 8;
    localparam int WRM = 4;
    localparam int DRN = 4;

    logic           clk;
    logic           reset_i;
    logic           en_i;
    logic [ELS-1:0] mask_i;
    logic [ELS-1:0] v_i;
    logic [ELS-1:0] ready_and_i;
    logic           armed_o;
    logic           trip_o;
    logic [1:0]     trip_idx_o;
    logic [63:0]    trip_cycle_o;
    logic           done_o;

    int          vec_cnt;
    int          err_cnt;
    logic [63:0] cyc;
    logic [63:0] exp_cyc;

    bp_nonsynth_if_watchdog_ctrl #(
        .els_p       (ELS),
        .timeout_p   (TMO),
        .warmup_p    (WRM),
        .drain_p     (DRN),
        .dev_p       ("if"),
        .finish_en_p (1'b0)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .en_i         (en_i),
        .mask_i       (mask_i),
        .v_i          (v_i),
        .ready_and_i  (ready_and_i),
        .armed_o      (armed_o),
        .trip_o       (trip_o),
        .trip_idx_o   (trip_idx_o),
        .trip_cycle_o (trip_cycle_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; cyc mirrors the free-running cycle count the DUT should hold.
    task automatic tick();
        logic r;
        r = reset_i;
        @(posedge clk);
        if (r) cyc = 64'd0;
        else   cyc = cyc + 64'd1;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        en_i        = 1'b0;
        mask_i      = '0;
        v_i         = '0;
        ready_and_i = '0;
        ticks(2);
        reset_i = 1'b0;
    endtask

    // From IDLE: one edge into WARMUP, warmup_p edges of counting to ARMED.
    task automatic arm(input string tag);
        en_i = 1'b1;
        ticks(WRM);
        chk_eq({tag, "_warm_armed"}, {63'd0, armed_o}, 64'd0);
        tick();
        chk_eq({tag, "_armed"}, {63'd0, armed_o}, 64'd1);
    endtask

    task automatic chk_trip(input string tag, input logic [1:0] idx);
        chk_eq({tag, "_trip"},  {63'd0, trip_o}, 64'd1);
        chk_eq({tag, "_idx"},   {62'd0, trip_idx_o}, {62'd0, idx});
        chk_eq({tag, "_armed0"}, {63'd0, armed_o}, 64'd0);
        exp_cyc = cyc - 64'd1;
        chk_eq({tag, "_cycle"}, trip_cycle_o, exp_cyc);
    endtask

    task automatic chk_drain(input string tag);
        ticks(DRN - 1);
        chk_eq({tag, "_drain_done"}, {63'd0, done_o}, 64'd0);
        tick();
        chk_eq({tag, "_done"}, {63'd0, done_o}, 64'd1);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        cyc     = 64'd0;

        // Reset state
        do_reset();
        chk_eq("rst_armed", {63'd0, armed_o}, 64'd0);
        chk_eq("rst_trip",  {63'd0, trip_o}, 64'd0);
        chk_eq("rst_idx",   {62'd0, trip_idx_o}, 64'd0);
        chk_eq("rst_cycle", trip_cycle_o, 64'd0);
        chk_eq("rst_done",  {63'd0, done_o}, 64'd0);

        // 1: ch2 stalls from the arm request; warmup must not count.
        mask_i = 4'b1111; v_i = 4'b0100; ready_and_i = 4'b0000;
        arm("t1");
        ticks(TMO);
        chk_eq("t1_pre_trip", {63'd0, trip_o}, 64'd0);
        tick();
        chk_trip("t1", 2'd2);
        chk_drain("t1");
        ticks(3);
        chk_eq("t1_done_hold", {63'd0, done_o}, 64'd1);
        chk_eq("t1_trip_hold", {63'd0, trip_o}, 64'd1);
        chk_eq("t1_idx_hold",  {62'd0, trip_idx_o}, 64'd2);

        // 2: handshake clears the count; v low holds it.
        do_reset();
        mask_i = 4'b1111; v_i = 4'b0000; ready_and_i = 4'b0000;
        arm("t2");
        v_i = 4'b0001;
        ticks(7);
        ready_and_i = 4'b0001;
        tick();
        ready_and_i = 4'b0000;
        ticks(7);
        chk_eq("t2_no_trip_a", {63'd0, trip_o}, 64'd0);
        v_i = 4'b0000;
        ticks(5);
        chk_eq("t2_no_trip_b", {63'd0, trip_o}, 64'd0);
        chk_eq("t2_still_armed", {63'd0, armed_o}, 64'd1);
        v_i = 4'b0001;
        tick();
        chk_eq("t2_no_trip_c", {63'd0, trip_o}, 64'd0);
        tick();
        chk_trip("t2", 2'd0);

        // 3: ch1 and ch3 tie; disarm in the trip cycle loses; en ignored in drain.
        do_reset();
        mask_i = 4'b1111; v_i = 4'b1010; ready_and_i = 4'b0000;
        arm("t3");
        ticks(TMO);
        chk_eq("t3_pre_trip", {63'd0, trip_o}, 64'd0);
        en_i = 1'b0;
        tick();
        chk_trip("t3", 2'd1);
        chk_drain("t3");

        // 4: masked channel does not count; unmasking restarts from zero.
        do_reset();
        mask_i = 4'b1011; v_i = 4'b0100; ready_and_i = 4'b0000;
        arm("t4");
        ticks(20);
        chk_eq("t4_masked", {63'd0, trip_o}, 64'd0);
        mask_i = 4'b1111;
        ticks(TMO);
        chk_eq("t4_pre_trip", {63'd0, trip_o}, 64'd0);
        tick();
        chk_trip("t4", 2'd2);

        // 5: disarm at count 5 clears counters; re-arm needs a full warmup.
        do_reset();
        mask_i = 4'b1111; v_i = 4'b0100; ready_and_i = 4'b0000;
        arm("t5a");
        ticks(5);
        chk_eq("t5_armed_mid", {63'd0, armed_o}, 64'd1);
        en_i = 1'b0;
        tick();
        chk_eq("t5_disarmed", {63'd0, armed_o}, 64'd0);
        chk_eq("t5_no_trip",  {63'd0, trip_o}, 64'd0);
        arm("t5b");
        ticks(TMO);
        chk_eq("t5_pre_trip", {63'd0, trip_o}, 64'd0);
        tick();
        chk_trip("t5", 2'd2);

        // 6: reset mid-drain aborts; a later trip still works.
        do_reset();
        mask_i = 4'b1111; v_i = 4'b0100; ready_and_i = 4'b0000;
        arm("t6a");
        ticks(TMO + 1);
        chk_eq("t6_trip_a", {63'd0, trip_o}, 64'd1);
        ticks(2);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk_eq("t6_rst_armed", {63'd0, armed_o}, 64'd0);
        chk_eq("t6_rst_trip",  {63'd0, trip_o}, 64'd0);
        chk_eq("t6_rst_idx",   {62'd0, trip_idx_o}, 64'd0);
        chk_eq("t6_rst_cycle", trip_cycle_o, 64'd0);
        chk_eq("t6_rst_done",  {63'd0, done_o}, 64'd0);
        en_i = 1'b0;
        ticks(DRN + 2);
        chk_eq("t6_no_done", {63'd0, done_o}, 64'd0);
        v_i = 4'b1000;
        arm("t6b");
        ticks(TMO);
        chk_eq("t6_pre_trip", {63'd0, trip_o}, 64'd0);
        tick();
        chk_trip("t6", 2'd3);
        chk_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
